// File: rtl/decode_queue_if.sv
// Fetch/execute-facing bundle of decode_queue.
// Handshake rule used on both sides: a transfer happens on a rising clock
// edge exactly when valid and ready are both high in that cycle; valid must
// not depend on ready, and the payload is only meaningful while valid is high.
// master: the fetch/execute side. slave: the queue itself.
interface decode_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Control and fetch side
  logic              flush;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;

  // Execute side
  logic              ctl_valid;
  logic              ctl_ready;

  // Decoded control word of the head entry
  logic              dwen;
  logic              dren;
  logic              branch;
  logic              jump;
  logic [3:0]        alu_op;
  logic [1:0]        alu_a_sel;
  logic [1:0]        alu_b_sel;
  logic [1:0]        w_sel;
  logic [3:0]        byte_en;
  logic [2:0]        load_type;
  logic [2:0]        branch_type;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic              muldiv;
  logic              illegal;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, instr_valid, instr, ctl_ready,
    input  instr_ready, ctl_valid, dwen, dren, branch, jump, alu_op,
           alu_a_sel, alu_b_sel, w_sel, byte_en, load_type, branch_type,
           rs1, rs2, rd, imm, muldiv, illegal, count
  );

  modport slave (
    input  flush, instr_valid, instr, ctl_ready,
    output instr_ready, ctl_valid, dwen, dren, branch, jump, alu_op,
           alu_a_sel, alu_b_sel, w_sel, byte_en, load_type, branch_type,
           rs1, rs2, rd, imm, muldiv, illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: decodes RV32I instruction words into a control word and
// buffers the results in a DEPTH-entry FIFO between fetch and execute.
// Optional feature macro: DECODE_MULDIV_EN -- when defined, OP instructions
// with funct7=0000001 decode as M-extension ops (muldiv=1); otherwise they
// are reported as illegal.
module decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  decode_queue_if.slave  q
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Operand / writeback selects
  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] W_ALU  = 2'd0;
  localparam logic [1:0] W_LOAD = 2'd1;
  localparam logic [1:0] W_PC4  = 2'd2;
  localparam logic [1:0] W_NONE = 2'd3;

  typedef struct packed {
    logic        dwen;
    logic        dren;
    logic        branch;
    logic        jump;
    logic [3:0]  alu_op;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [1:0]  w_sel;
    logic [3:0]  byte_en;
    logic [2:0]  load_type;
    logic [2:0]  branch_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        muldiv;
    logic        illegal;
  } ctl_t;

  ctl_t             mem [DEPTH];
  ctl_t             dec;
  ctl_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             instr_ready;
  logic             ctl_valid;
  logic             push;
  logic             pop;
  logic             bad;

  // Instruction fields and immediates by format
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = q.instr[6:0];
  assign funct3 = q.instr[14:12];
  assign funct7 = q.instr[31:25];
  assign imm_i  = {{20{q.instr[31]}}, q.instr[31:20]};
  assign imm_s  = {{20{q.instr[31]}}, q.instr[31:25], q.instr[11:7]};
  assign imm_b  = {{19{q.instr[31]}}, q.instr[31], q.instr[7],
                   q.instr[30:25], q.instr[11:8], 1'b0};
  assign imm_u  = {q.instr[31:12], 12'h000};
  assign imm_j  = {{11{q.instr[31]}}, q.instr[31], q.instr[19:12],
                   q.instr[20], q.instr[30:21], 1'b0};

  // Handshake qualifiers; flush blocks acceptance so a same-cycle push is dropped
  assign instr_ready = (count < DEPTH_C) && !q.flush;
  assign ctl_valid   = (count != '0);
  assign push        = q.instr_valid && instr_ready;
  assign pop         = ctl_valid && q.ctl_ready;

  // Decode the offered instruction word into a control word
  always_comb begin
    dec       = '0;
    dec.w_sel = W_NONE;
    bad       = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.alu_a_sel = A_ZERO;
        dec.alu_b_sel = B_IMM;
        dec.w_sel     = W_ALU;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.alu_a_sel = A_PC;
        dec.alu_b_sel = B_IMM;
        dec.w_sel     = W_ALU;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.alu_a_sel = A_PC;
        dec.alu_b_sel = B_IMM;
        dec.w_sel     = W_PC4;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.alu_a_sel = A_RS1;
        dec.alu_b_sel = B_IMM;
        dec.w_sel     = W_PC4;
        dec.imm       = imm_i;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) begin
          bad = 1'b1;
        end else begin
          dec.branch      = 1'b1;
          dec.branch_type = funct3;
          dec.imm         = imm_b;
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
          bad = 1'b1;
        end else begin
          dec.dren      = 1'b1;
          dec.load_type = funct3;
          dec.alu_b_sel = B_IMM;
          dec.w_sel     = W_LOAD;
          dec.imm       = imm_i;
        end
      end
      OPC_STORE: begin
        if (funct3 > 3'd2) begin
          bad = 1'b1;
        end else begin
          dec.dwen      = 1'b1;
          dec.alu_b_sel = B_IMM;
          dec.imm       = imm_s;
          case (funct3)
            3'd0:    dec.byte_en = 4'b0001;
            3'd1:    dec.byte_en = 4'b0011;
            default: dec.byte_en = 4'b1111;
          endcase
        end
      end
      OPC_OPIMM: begin
        // Only shift-right immediates carry the arithmetic/logical bit
        dec.alu_op    = {(funct3 == 3'd5) && q.instr[30], funct3};
        dec.alu_b_sel = B_IMM;
        dec.w_sel     = W_ALU;
        dec.imm       = imm_i;
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.alu_op = {funct7[5], funct3};
          dec.w_sel  = W_ALU;
        end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
          dec.muldiv = 1'b1;
          dec.alu_op = {1'b0, funct3};
          dec.w_sel  = W_ALU;
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OPC_FENCE: begin
        // Executes as a no-op: no write, no memory access
      end
      default: bad = 1'b1;
    endcase

    // An illegal word carries no side effects downstream
    if (bad) begin
      dec         = '0;
      dec.w_sel   = W_NONE;
      dec.illegal = 1'b1;
    end
    dec.rs1 = q.instr[19:15];
    dec.rs2 = q.instr[24:20];
    dec.rd  = (dec.w_sel == W_NONE) ? 5'd0 : q.instr[11:7];
  end

  // Entry storage: written on accepted push, never reset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Pointers and occupancy; reset dominates flush, flush dominates push/pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (q.flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry, masked to zero while the queue is empty
  always_comb begin
    head = '0;
    if (ctl_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign q.instr_ready = instr_ready;
  assign q.ctl_valid   = ctl_valid;
  assign q.count       = count;
  assign q.dwen        = head.dwen;
  assign q.dren        = head.dren;
  assign q.branch      = head.branch;
  assign q.jump        = head.jump;
  assign q.alu_op      = head.alu_op;
  assign q.alu_a_sel   = head.alu_a_sel;
  assign q.alu_b_sel   = head.alu_b_sel;
  assign q.w_sel       = head.w_sel;
  assign q.byte_en     = head.byte_en;
  assign q.load_type   = head.load_type;
  assign q.branch_type = head.branch_type;
  assign q.rs1         = head.rs1;
  assign q.rs2         = head.rs2;
  assign q.rd          = head.rd;
  assign q.imm         = head.imm;
  assign q.muldiv      = head.muldiv;
  assign q.illegal     = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: directed cases followed by random push/pop
// traffic, all checked against a reference decoder and an expected queue.
module tb_decode_queue;
  localparam int DEPTH = 4;

  typedef logic [72:0] word_t;

  logic  clk;
  logic  rst;
  int    tests_run;
  int    tests_failed;
  word_t exp_q[$];

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                           7'h03, 7'h23, 7'h13, 7'h33, 7'h0f};

  decode_queue_if #(.DEPTH(DEPTH)) q ();

  decode_queue #(.DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .q   (q)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observed head control word, in the same field order as ref_decode
  function automatic word_t got_word();
    return {q.dwen, q.dren, q.branch, q.jump, q.alu_op, q.alu_a_sel,
            q.alu_b_sel, q.w_sel, q.byte_en, q.load_type, q.branch_type,
            q.rs1, q.rs2, q.rd, q.imm, q.muldiv, q.illegal};
  endfunction

  // Reference RV32I decoder
  function automatic word_t ref_decode(input logic [31:0] w);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        st, ld, br, jp, md, ill;
    logic [3:0]  aop, be;
    logic [1:0]  asel, bsel, ws;
    logic [2:0]  lt, bt;
    logic [31:0] im;
    logic [4:0]  rdv;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    st = 0; ld = 0; br = 0; jp = 0; md = 0; ill = 0;
    aop = 0; be = 0; asel = 0; bsel = 0; ws = 2'd3; lt = 0; bt = 0; im = 0;
    case (op)
      7'h37: begin asel = 2; bsel = 1; ws = 0; im = {w[31:12], 12'h0}; end
      7'h17: begin asel = 1; bsel = 1; ws = 0; im = {w[31:12], 12'h0}; end
      7'h6f: begin
        jp = 1; ws = 2; asel = 1; bsel = 1;
        im = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      end
      7'h67: begin jp = 1; ws = 2; bsel = 1; im = {{20{w[31]}}, w[31:20]}; end
      7'h63: begin
        if (f3 == 2 || f3 == 3) ill = 1;
        br = 1; bt = f3;
        im = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      end
      7'h03: begin
        if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
        ld = 1; ws = 1; lt = f3; bsel = 1; im = {{20{w[31]}}, w[31:20]};
      end
      7'h23: begin
        if (f3 > 2) ill = 1;
        st = 1; bsel = 1; im = {{20{w[31]}}, w[31:25], w[11:7]};
        be = (f3 == 0) ? 4'b0001 : (f3 == 1) ? 4'b0011 : 4'b1111;
      end
      7'h13: begin
        ws = 0; bsel = 1; im = {{20{w[31]}}, w[31:20]};
        aop = {(f3 == 3'd5) ? w[30] : 1'b0, f3};
      end
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          ws = 0; aop = {w[30], f3};
        end else if (f7 == 7'h01) begin
`ifdef DECODE_MULDIV_EN
          md = 1; ws = 0; aop = {1'b0, f3};
`else
          ill = 1;
`endif
        end else begin
          ill = 1;
        end
      end
      7'h0f: ;
      default: ill = 1;
    endcase
    if (ill) begin
      st = 0; ld = 0; br = 0; jp = 0; md = 0; aop = 0; asel = 0; bsel = 0;
      be = 0; lt = 0; bt = 0; im = 0; ws = 2'd3;
    end
    rdv = (ws == 2'd3) ? 5'd0 : w[11:7];
    return {st, ld, br, jp, aop, asel, bsel, ws, be, lt, bt,
            w[19:15], w[24:20], rdv, im, md, ill};
  endfunction

  // Driver: apply one cycle of inputs at the falling edge, check the DUT
  // against the scoreboard, then advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic r,
                       input logic f);
    int   sz;
    logic do_push;
    logic do_pop;
    q.instr_valid = v;
    q.instr       = w;
    q.ctl_ready   = r;
    q.flush       = f;
    #1;
    sz = exp_q.size();
    check("count", word_t'(q.count), word_t'(sz));
    check("ctl_valid", word_t'(q.ctl_valid), word_t'(sz != 0));
    check("instr_ready", word_t'(q.instr_ready), word_t'((sz < DEPTH) && !f));
    if (sz != 0) check("head", got_word(), exp_q[0]);
    else         check("empty_out", got_word(), '0);
    do_push = v && (sz < DEPTH) && !f;
    do_pop  = (sz != 0) && r;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_decode(w));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    q.instr_valid = 1'b0;
    q.instr       = '0;
    q.ctl_ready   = 1'b0;
    q.flush       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    #1;
    check("rst_count", word_t'(q.count), '0);
    check("rst_ctl_valid", word_t'(q.ctl_valid), '0);
    check("rst_instr_ready", word_t'(q.instr_ready), word_t'(1));
    check("rst_outputs", got_word(), '0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    @(negedge clk);
    do_reset();

    // addi x1,x0,5
    cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    check("addi_valid", word_t'(q.ctl_valid), word_t'(1));
    check("addi_rd", word_t'(q.rd), word_t'(1));
    check("addi_imm", word_t'(q.imm), word_t'(5));
    check("addi_bsel", word_t'(q.alu_b_sel), word_t'(1));
    check("addi_wsel", word_t'(q.w_sel), word_t'(0));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // sw x2,-4(x1)
    cycle(1'b1, 32'hFE20AE23, 1'b0, 1'b0);
    check("sw_dwen", word_t'(q.dwen), word_t'(1));
    check("sw_byte_en", word_t'(q.byte_en), word_t'(4'b1111));
    check("sw_imm", word_t'(q.imm), word_t'(32'hFFFFFFFC));
    check("sw_rs1", word_t'(q.rs1), word_t'(1));
    check("sw_rs2", word_t'(q.rs2), word_t'(2));
    check("sw_wsel", word_t'(q.w_sel), word_t'(3));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill to DEPTH, hold a fifth, then pop/push across the pointer wrap
    cycle(1'b1, 32'h00100113, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000A183, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208463, 1'b0, 1'b0);
    cycle(1'b1, 32'h123452B7, 1'b0, 1'b0);
    check("full_count", word_t'(q.count), word_t'(4));
    check("full_ready", word_t'(q.instr_ready), '0);
    cycle(1'b1, 32'h008000EF, 1'b0, 1'b0);
    cycle(1'b1, 32'h008000EF, 1'b1, 1'b0);
    cycle(1'b1, 32'h40315233, 1'b1, 1'b0);
    cycle(1'b1, 32'h00009067, 1'b0, 1'b0);
    check("wrap_count", word_t'(q.count), word_t'(4));
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush at count=3 with a push and a pop offered in the same cycle
    cycle(1'b1, 32'h00100113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200193, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300213, 1'b0, 1'b0);
    cycle(1'b1, 32'h00400293, 1'b1, 1'b1);
    check("flush_count", word_t'(q.count), '0);
    check("flush_valid", word_t'(q.ctl_valid), '0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // mul x3,x1,x2
    cycle(1'b1, 32'h022081B3, 1'b0, 1'b0);
`ifdef DECODE_MULDIV_EN
    check("mul_muldiv", word_t'(q.muldiv), word_t'(1));
    check("mul_illegal", word_t'(q.illegal), '0);
`else
    check("mul_illegal", word_t'(q.illegal), word_t'(1));
    check("mul_wsel", word_t'(q.w_sel), word_t'(3));
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);

    // ecall
    cycle(1'b1, 32'h00000073, 1'b0, 1'b0);
    check("ecall_illegal", word_t'(q.illegal), word_t'(1));
    check("ecall_dwen", word_t'(q.dwen), '0);
    check("ecall_dren", word_t'(q.dren), '0);
    check("ecall_rd", word_t'(q.rd), '0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream discards queued entries
    cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600113, 1'b0, 1'b0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_instr(),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
    end
    repeat (DEPTH + 1) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
